// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_seq_pkg                                                       |
// | Shared op codes, step-mode type and helpers for the mul/div block.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package muldiv_seq_pkg;

  localparam int unsigned MD_DATA_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_seq_if                                                        |
// | Request/response bundle between the execute stage and muldiv_seq.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface muldiv_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_en;
  logic                  i_kill;
  logic [2:0]            i_operation;
  logic [DATA_WIDTH-1:0] i_data_a;
  logic [DATA_WIDTH-1:0] i_data_b;
  logic [DATA_WIDTH-1:0] o_dout;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_div_zero;

  modport master (
    output i_en, i_kill, i_operation, i_data_a, i_data_b,
    input  o_dout, o_busy, o_done, o_div_zero
  );

  modport slave (
    input  i_en, i_kill, i_operation, i_data_a, i_data_b,
    output o_dout, o_busy, o_done, o_div_zero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_step                                                          |
// | One radix-2 iteration: shift-add multiply or restoring divide.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  step_mode_e              mode_i,
  input  logic [2*DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0]   operand_i,
  output logic [2*DATA_WIDTH-1:0] acc_o
);

  logic [DATA_WIDTH:0] w_sum;
  logic [DATA_WIDTH:0] w_shifted;
  logic [DATA_WIDTH:0] w_diff;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  always_comb begin
    w_sum     = {1'b0, acc_i[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, operand_i};
    w_shifted = acc_i[2*DATA_WIDTH-1:DATA_WIDTH-1];
    w_diff    = w_shifted - {1'b0, operand_i};
    acc_o     = acc_i;
    if (mode_i == STEP_MUL) begin
      if (acc_i[0]) begin
        acc_o = {w_sum, acc_i[DATA_WIDTH-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*DATA_WIDTH-1:1]};
      end
    end else begin
      if (w_diff[DATA_WIDTH]) begin
        acc_o = {w_shifted[DATA_WIDTH-1:0], acc_i[DATA_WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {w_diff[DATA_WIDTH-1:0], acc_i[DATA_WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_seq                                                           |
// | Iterative mul/div sequencer owning the HI/LO registers.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] C_CNT_START = CNT_WIDTH'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   opb_q, opb_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic                    is_div_q, is_div_d;
  logic                    neg_q, neg_d;
  logic                    neg_rem_q, neg_rem_d;

  logic                    w_signed;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [DATA_WIDTH-1:0]   w_abs_a;
  logic [DATA_WIDTH-1:0]   w_abs_b;
  logic [2*DATA_WIDTH-1:0] w_step_acc;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_quo;
  logic [DATA_WIDTH-1:0]   w_rem;
  logic                    w_done;
  step_mode_e              w_mode;

  assign w_signed = is_signed_op(bus.i_operation);
  assign w_a_neg  = w_signed & bus.i_data_a[DATA_WIDTH-1];
  assign w_b_neg  = w_signed & bus.i_data_b[DATA_WIDTH-1];
  assign w_abs_a  = w_a_neg ? -bus.i_data_a : bus.i_data_a;
  assign w_abs_b  = w_b_neg ? -bus.i_data_b : bus.i_data_b;
  assign w_mode   = (state_q == S_DIV) ? STEP_DIV : STEP_MUL;

  muldiv_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .mode_i   (w_mode),
    .acc_i    (acc_q),
    .operand_i(opb_q),
    .acc_o    (w_step_acc)
  );

  // Sign fix-up applied in FIX on magnitude results.
  assign w_prod = neg_q ? -acc_q : acc_q;
  assign w_quo  = neg_q ? -acc_q[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
  assign w_rem  = neg_rem_q ? -acc_q[2*DATA_WIDTH-1:DATA_WIDTH]
                            : acc_q[2*DATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    w_done    = 1'b0;
    if (bus.i_kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_en) begin
            case (bus.i_operation)
              OP_MULT, OP_MULTU: begin
                state_d   = S_MUL;
                cnt_d     = C_CNT_START;
                acc_d     = {{DATA_WIDTH{1'b0}}, w_abs_b};
                opb_d     = w_abs_a;
                is_div_d  = 1'b0;
                neg_d     = w_a_neg ^ w_b_neg;
                neg_rem_d = 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                if (bus.i_data_b != '0) begin
                  state_d   = S_DIV;
                  cnt_d     = C_CNT_START;
                  acc_d     = {{DATA_WIDTH{1'b0}}, w_abs_a};
                  opb_d     = w_abs_b;
                  is_div_d  = 1'b1;
                  neg_d     = w_a_neg ^ w_b_neg;
                  neg_rem_d = w_a_neg;
                end
              end
              OP_MTHI: hi_d = bus.i_data_a;
              OP_MTLO: lo_d = bus.i_data_a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          acc_d = w_step_acc;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          w_done  = 1'b1;
          state_d = S_IDLE;
          if (is_div_q) begin
            hi_d = w_rem;
            lo_d = w_quo;
          end else begin
            hi_d = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            lo_d = w_prod[DATA_WIDTH-1:0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_done     = w_done;
  assign bus.o_div_zero = (state_q == S_IDLE) & bus.i_en & (bus.i_data_b == '0) &
                          ((bus.i_operation == OP_DIV) | (bus.i_operation == OP_DIVU));
  assign bus.o_dout     = (bus.i_operation == OP_MFHI) ? hi_q :
                          (bus.i_operation == OP_MFLO) ? lo_q : '0;

endmodule
`default_nettype wire
